// File: rtl/fp_div_sched.sv
// Round-robin scheduler sharing one pipelined fp divider among NREQ requesters.
// Optional FP_DIV_SCHED_DIVZERO_EN adds a res_dz divide-by-zero flag carried with each result.
module fp_div_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_mod,
    output logic [31:0]          div_ain,
    output logic [31:0]          div_bin,
    output logic                 div_vldin,
    output logic                 div_take_mod,
    output logic                 div_en,
    input  logic [31:0]          div_out,
    input  logic                 div_vldout,
    output logic [NREQ-1:0]      res_vld,
    output logic [31:0]          res_data,
    output logic                 err
`ifdef FP_DIV_SCHED_DIVZERO_EN
    ,
    output logic                 res_dz
`endif
);

    localparam int PW = $clog2(NREQ);

    logic [31:0]     a_arr [NREQ];
    logic [31:0]     b_arr [NREQ];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic            grant;
    logic [LAT-1:0]  tag_v;
    logic [PW-1:0]   tag_i [LAT];
    logic [NREQ-1:0] res_oh;
    logic            hit;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign a_arr[g] = req_a[32*g +: 32];
        assign b_arr[g] = req_b[32*g +: 32];
    end

    assign div_en = !hold;

    // Handshake: a transfer happens on a rising edge where req_vld[i] & req_rdy[i];
    // req_rdy is combinational from req_vld, at most one bit set, never set under hold.
    always_comb begin
        logic [PW-1:0] idx;
        int            j;
        grant   = 1'b0;
        win     = '0;
        req_rdy = '0;
        idx     = '0;
        j       = 0;
        if (!hold) begin
            for (int i = 0; i < NREQ; i++) begin
                j = int'(ptr) + i;
                if (j >= NREQ) j = j - NREQ;
                idx = PW'(j);
                if (!grant && req_vld[idx]) begin
                    grant = 1'b1;
                    win   = idx;
                end
            end
        end
        if (grant) req_rdy[win] = 1'b1;
    end

    always_comb begin
        res_oh = '0;
        res_oh[tag_i[LAT-1]] = 1'b1;
    end

    // The operand register is the first of the LAT divider stages, so the tag
    // at stage LAT-1 lines up with div_vldout.
    assign hit = div_vldout && tag_v[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            tag_v        <= '0;
            for (int k = 0; k < LAT; k++) tag_i[k] <= '0;
            div_ain      <= '0;
            div_bin      <= '0;
            div_take_mod <= 1'b0;
            div_vldin    <= 1'b0;
            res_vld      <= '0;
            res_data     <= '0;
            err          <= 1'b0;
        end else if (div_en) begin
            tag_v    <= {tag_v[LAT-2:0], grant};
            tag_i[0] <= win;
            for (int k = 1; k < LAT; k++) tag_i[k] <= tag_i[k-1];
            div_vldin <= grant;
            if (grant) begin
                ptr          <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
                div_ain      <= a_arr[win];
                div_bin      <= b_arr[win];
                div_take_mod <= req_mod[win];
            end
            res_vld <= hit ? res_oh : '0;
            if (hit) res_data <= div_out;
            // Either side of a valid mismatch at the final stage is a protocol error.
            err <= err | (div_vldout ^ tag_v[LAT-1]);
        end
    end

`ifdef FP_DIV_SCHED_DIVZERO_EN
    logic [LAT-1:0] tag_dz;
    logic           dz_new;

    assign dz_new = grant && (b_arr[win][30:0] == 31'd0) && !req_mod[win];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_dz <= '0;
            res_dz <= 1'b0;
        end else if (div_en) begin
            tag_dz <= {tag_dz[LAT-2:0], dz_new};
            res_dz <= hit && tag_dz[LAT-1];
        end
    end
`endif

endmodule

// File: tb/tb_fp_div_sched.sv
// Directed bench for fp_div_sched with a behavioural LAT-stage divider model.
// Define FP_DIV_SCHED_DIVZERO_EN to also exercise res_dz.
module tb_fp_div_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hold = 1'b0;
    logic [NREQ-1:0]  req_vld = '0;
    logic [NREQ-1:0]  req_rdy;
    logic [127:0]     req_a;
    logic [127:0]     req_b;
    logic [NREQ-1:0]  req_mod;
    logic [31:0]      div_ain, div_bin, div_out;
    logic             div_vldin, div_take_mod, div_en, div_vldout;
    logic [NREQ-1:0]  res_vld;
    logic [31:0]      res_data;
    logic             err;
    logic             spur = 1'b0;
`ifdef FP_DIV_SCHED_DIVZERO_EN
    logic             res_dz;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;
    logic last_en = 1'b0;

    logic [31:0]     exp_q[$];
    logic [NREQ-1:0] exp_vld_q[$];
    int              exp_t_q[$];
    logic            exp_dz_q[$];

    fp_div_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a(req_a), .req_b(req_b), .req_mod(req_mod),
        .div_ain(div_ain), .div_bin(div_bin), .div_vldin(div_vldin),
        .div_take_mod(div_take_mod), .div_en(div_en),
        .div_out(div_out), .div_vldout(div_vldout),
        .res_vld(res_vld), .res_data(res_data), .err(err)
`ifdef FP_DIV_SCHED_DIVZERO_EN
        , .res_dz(res_dz)
`endif
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        last_en = !hold && rst_n;
        if (last_en) en_cnt++;
    end

    // ---------------- divider model ----------------
    function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b,
                                             input logic m);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ {31'b0, m};
    endfunction

    logic [LAT-2:0] dv_v;
    logic [31:0]    dv_d [LAT-1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_v <= '0;
        end else if (div_en) begin
            dv_v    <= {dv_v[LAT-3:0], div_vldin};
            dv_d[0] <= fake_div(div_ain, div_bin, div_take_mod);
            for (int k = 1; k < LAT-1; k++) dv_d[k] <= dv_d[k-1];
        end
    end

    assign div_vldout = dv_v[LAT-2] | spur;
    assign div_out    = dv_d[LAT-2];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every new result after an enabled edge must match the queue head.
    always @(negedge clk) begin
        if (rst_n && last_en && res_vld != '0) begin
            if (exp_q.size() == 0) begin
                check("res_unexpected", {28'b0, res_vld}, 32'd0);
            end else begin
                check("res_vld", {28'b0, res_vld}, {28'b0, exp_vld_q.pop_front()});
                check("res_data", res_data, exp_q.pop_front());
                check("res_latency", en_cnt, exp_t_q.pop_front());
`ifdef FP_DIV_SCHED_DIVZERO_EN
                check("res_dz", {31'b0, res_dz}, {31'b0, exp_dz_q.pop_front()});
`else
                void'(exp_dz_q.pop_front());
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [NREQ-1:0] vld, input logic hld,
                         input logic [NREQ-1:0] exp_rdy, input logic exp_dz);
        @(negedge clk);
        req_vld = vld;
        hold    = hld;
        #1;
        check("req_rdy", {28'b0, req_rdy}, {28'b0, exp_rdy});
        check("div_en", {31'b0, div_en}, {31'b0, !hld});
        for (int i = 0; i < NREQ; i++) begin
            if (exp_rdy[i]) begin
                exp_q.push_back(fake_div(req_a[32*i +: 32], req_b[32*i +: 32], req_mod[i]));
                exp_vld_q.push_back(exp_rdy);
                exp_t_q.push_back(en_cnt + LAT + 1);
                exp_dz_q.push_back(exp_dz);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_vld = '0;
            hold    = 1'b0;
        end
    endtask

    task automatic check_drained(input string tag);
        check(tag, exp_q.size(), 32'd0);
        check("err_clear", {31'b0, err}, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_res_vld", {28'b0, res_vld}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_div_ain", div_ain, 32'd0);
        check("rst_div_bin", div_bin, 32'd0);
        check("rst_div_vldin", {31'b0, div_vldin}, 32'd0);
        check("rst_div_take_mod", {31'b0, div_take_mod}, 32'd0);
        check("rst_req_rdy", {28'b0, req_rdy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = 32'h3F80_0000 + 32'(i << 20);
            req_b[32*i +: 32] = 32'h4000_0000 + 32'(i << 4);
        end
        req_a[31:0] = 32'h40C0_0000;
        req_b[31:0] = 32'h4000_0000;
        req_mod     = 4'b1010;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 0.
        drive(4'b0001, 1'b0, 4'b0001, 1'b0);
        idle(13);
        check_drained("drain_single");

        // Move pointer back to 0, then all four requesting for 8 cycles.
        drive(4'b1000, 1'b0, 4'b1000, 1'b0);
        for (int i = 0; i < 8; i++) drive(4'b1111, 1'b0, 4'(1 << (i % 4)), 1'b0);
        idle(14);
        check_drained("drain_rr");

        // Hold for 3 cycles with operations in flight.
        drive(4'b1111, 1'b0, 4'b0001, 1'b0);
        drive(4'b1111, 1'b0, 4'b0010, 1'b0);
        repeat (3) drive(4'b1111, 1'b1, 4'b0000, 1'b0);
        drive(4'b1111, 1'b0, 4'b0100, 1'b0);
        idle(14);
        check_drained("drain_hold");

        // Reset with 5 operations in flight and pointer at 2.
        drive(4'b1111, 1'b0, 4'b1000, 1'b0);
        drive(4'b1111, 1'b0, 4'b0001, 1'b0);
        drive(4'b1111, 1'b0, 4'b0010, 1'b0);
        drive(4'b1111, 1'b0, 4'b0100, 1'b0);
        drive(4'b0010, 1'b0, 4'b0010, 1'b0);
        @(negedge clk);
        req_vld = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        exp_vld_q.delete();
        exp_t_q.delete();
        exp_dz_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, 1'b0, 4'b0001, 1'b0);
        idle(14);
        check_drained("drain_reset");

        // Divide-by-zero flag: -0.0 divisor flagged, 1.0 divisor not.
        idle(1);
        req_b[95:64]  = 32'h8000_0000;
        req_b[127:96] = 32'h3F80_0000;
        req_mod       = 4'b0010;
        drive(4'b0100, 1'b0, 4'b0100, 1'b1);
        drive(4'b1000, 1'b0, 4'b1000, 1'b0);
        idle(14);
        check_drained("drain_dz");

        // Spurious divider valid with an empty tag pipeline.
        @(negedge clk);
        spur = 1'b1;
        #1;
        check("err_before_spur", {31'b0, err}, 32'd0);
        @(negedge clk);
        spur = 1'b0;
        #1;
        check("err_set", {31'b0, err}, 32'd1);
        check("spur_no_res", {28'b0, res_vld}, 32'd0);
        idle(5);
        #1;
        check("err_sticky", {31'b0, err}, 32'd1);
        check("spur_no_res_late", {28'b0, res_vld}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
